periph_rx_arbiter: RTL

Round-robin arbiter that shares the single upstream USB transmit path between all reconfigurable peripheral slots. It drains each slot's local RX FIFO (peripheral-to-host, address-less payload), prepends the slot's peripheral address, and writes full-width USB packets into the shared host-bound FIFO. It sits between the per-slot RX FIFOs fed by the peripheral wrappers and the USB packetizer FIFO.

---
 rtl/lycan_globals.sv | 14 +
 rtl/rr_priority_select.sv | 31 +++
 rtl/periph_rx_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/lycan_globals.sv
// Project-wide constants and shared types for the peripheral slot fabric.
package lycan_globals;

    localparam int unsigned num_peripherals      = 4;
    localparam int unsigned usb_packet_width     = 32;
    localparam int unsigned periph_address_width = 4;
    localparam int unsigned rx_arb_max_burst     = 4;

    typedef enum logic {
        ARB  = 1'b0,
        XFER = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin find-first: first set req at or after ptr, wrapping modulo N.
module rr_priority_select #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

    int unsigned slot;

    // Scan from the far end so the candidate closest to ptr wins last.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        slot    = 0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            slot = 32'(ptr_i) + 32'(k);
            if (slot >= N) begin
                slot = slot - N;
            end
            if (req_i[IW'(slot)]) begin
                valid_o = 1'b1;
                idx_o   = IW'(slot);
            end
        end
    end

endmodule

// File: rtl/periph_rx_arbiter.sv
// Round-robin drain of per-slot RX FIFOs into the shared host-bound USB FIFO.
// Optional per-slot packet counters are enabled with PERIPH_RX_ARB_STATS_EN.
module periph_rx_arbiter
    import lycan_globals::*;
#(
    parameter  int unsigned NUM_PERIPH = num_peripherals,
    parameter  int unsigned MAX_BURST  = rx_arb_max_burst,
    parameter  int unsigned PAYLOAD_W  = usb_packet_width - periph_address_width,
    localparam int unsigned GW         = $clog2(NUM_PERIPH)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_PERIPH-1:0]                periph_en,
    input  logic [NUM_PERIPH-1:0][PAYLOAD_W-1:0] rx_data,
    input  logic [NUM_PERIPH-1:0]                rx_empty,
    output logic [NUM_PERIPH-1:0]                rx_rden,
    output logic [usb_packet_width-1:0]          usb_data,
    output logic                                 usb_wren,
    input  logic                                 usb_full,
    output logic [GW-1:0]                        grant,
    output logic                                 idle
`ifdef PERIPH_RX_ARB_STATS_EN
    ,
    output logic [NUM_PERIPH-1:0][15:0]          pkt_count
`endif
);

    localparam int unsigned AW = periph_address_width;
    localparam int unsigned UW = usb_packet_width;
    localparam int unsigned BW = 8;

    arb_state_t            state_q, state_d;
    logic [GW-1:0]         grant_q, grant_d;
    logic [GW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]         burst_q, burst_d;
    logic [NUM_PERIPH-1:0] req;
    logic                  sel_valid;
    logic [GW-1:0]         sel_idx;
    logic [GW-1:0]         ptr_next;
    logic                  xfer;

    assign req      = periph_en & ~rx_empty;
    assign grant    = grant_q;
    assign ptr_next = (grant_q == GW'(NUM_PERIPH - 1)) ? '0 : grant_q + GW'(1);

    rr_priority_select #(.N(NUM_PERIPH)) u_sel (
        .req_i   (req),
        .ptr_i   (rr_ptr_q),
        .valid_o (sel_valid),
        .idx_o   (sel_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ARB;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            burst_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            burst_q  <= burst_d;
        end
    end

    // A full host FIFO only stalls; the grant is released on empty/disable or burst end.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        burst_d  = burst_q;
        rx_rden  = '0;
        usb_wren = 1'b0;
        xfer     = 1'b0;
        idle     = 1'b0;
        usb_data = UW'({AW'(grant_q), rx_data[grant_q]});
        unique case (state_q)
            ARB: begin
                idle = ~|req;
                if (sel_valid) begin
                    grant_d = sel_idx;
                    burst_d = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                xfer = req[grant_q] & ~usb_full;
                if (!req[grant_q]) begin
                    state_d  = ARB;
                    rr_ptr_d = ptr_next;
                end else if (xfer) begin
                    rx_rden[grant_q] = 1'b1;
                    usb_wren         = 1'b1;
                    burst_d          = burst_q + BW'(1);
                    if (burst_q == BW'(MAX_BURST - 1)) begin
                        state_d  = ARB;
                        rr_ptr_d = ptr_next;
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

`ifdef PERIPH_RX_ARB_STATS_EN
    logic [NUM_PERIPH-1:0][15:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (usb_wren) begin
            cnt_q[grant_q] <= cnt_q[grant_q] + 16'd1;
        end
    end

    assign pkt_count = cnt_q;
`endif

endmodule
